// File: rtl/kmx_pkg.sv
// kmx_pkg: shared matrix size defaults, key event type and key index helper
package kmx_pkg;
   localparam int KMX_ROWS = 8;
   localparam int KMX_COLS = 8;
   localparam int KMX_RW = $clog2(KMX_ROWS);
   localparam int KMX_CW = $clog2(KMX_COLS);
   typedef struct packed {
      logic              press;
      logic [KMX_RW-1:0] row;
      logic [KMX_CW-1:0] col;
   } key_evt_t;
   function automatic int key_index(input int row, input int col);
      return row * KMX_COLS + col;
   endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous key event FIFO with valid/ready head and same-cycle push/pop
module key_evt_fifo
   import kmx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  key_evt_t din,
   output logic     full,
   output logic     valid,
   input  logic     ready,
   output key_evt_t head
);
   localparam int AW = $clog2(DEPTH);
   key_evt_t mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic pop, wr_en;
   // status flags; a pop frees the slot so a push into a full FIFO is still taken
   always_comb begin
      valid = wr_ptr != rd_ptr;
      full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop = valid && ready;
      wr_en = push && (!full || pop);
      head = valid ? mem[rd_ptr[AW-1:0]] : '0;
   end
   // pointers carry an extra wrap bit to tell full from empty
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   // storage is not reset; the head is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: row-strobed key matrix scan with per-key debounce and event FIFO
module key_matrix_scanner
   import kmx_pkg::*;
#(
   parameter int ROWS       = KMX_ROWS,
   parameter int COLS       = KMX_COLS,
   parameter int SCAN_DIV   = 8192,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ROWS-1:0]         row_n,
   input  logic [COLS-1:0]         col_n,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic                    evt_press,
   output logic [$clog2(ROWS)-1:0] evt_row,
   output logic [$clog2(COLS)-1:0] evt_col,
   output logic [ROWS*COLS-1:0]    key_state,
   output logic                    overflow,
   input  logic                    ovf_clr
);
   localparam int RW  = $clog2(ROWS);
   localparam int CW  = $clog2(COLS);
   localparam int KW  = $clog2(ROWS*COLS);
   localparam int DVW = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE + 1);
   logic [DVW-1:0] div;
   logic [RW-1:0] row_idx, samp_row;
   logic [COLS-1:0] samp;
   logic [DBW-1:0] cnt [ROWS*COLS];
   logic [CW-1:0] c;
   logic [KW-1:0] k;
   logic proc, s, flip, full, drop;
   key_evt_t evt, head;
   // one column of the previous row's sample is judged per cycle at the start of each slot
   always_comb begin
      proc = div < DVW'(COLS);
      c = div[CW-1:0];
      k = KW'(key_index(int'(samp_row), int'(c)));
      s = ~samp[c];
      flip = proc && (s != key_state[k]) && (cnt[k] == DBW'(DEBOUNCE - 1));
      evt = '{press: s, row: samp_row, col: c};
      drop = flip && full && !(evt_valid && evt_ready);
      row_n = rst ? ~(ROWS'(1) << row_idx) : '1;
   end
   // divider and row strobe; columns are sampled late in the slot so they have settled
   always_ff @(posedge clk) begin
      if (!rst) begin
         div <= '0;
         row_idx <= '0;
         samp_row <= '0;
         samp <= '1;
      end else begin
         div <= (div == DVW'(SCAN_DIV - 1)) ? '0 : div + DVW'(1);
         if (div == DVW'(SCAN_DIV - 1)) begin
            samp <= col_n;
            samp_row <= row_idx;
            row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
         end
      end
   end
   // debounce counters and stable map; key_state flips even when the event is dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_state <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < ROWS*COLS; i++) cnt[i] <= '0;
      end else begin
         if (proc) begin
            cnt[k] <= (s == key_state[k] || flip) ? '0 : cnt[k] + DBW'(1);
            if (flip) key_state[k] <= s;
         end
         overflow <= drop | (overflow & ~ovf_clr);
      end
   end
   key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (flip),
      .din   (evt),
      .full  (full),
      .valid (evt_valid),
      .ready (evt_ready),
      .head  (head)
   );
   assign evt_press = head.press;
   assign evt_row = head.row;
   assign evt_col = head.col;
endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Input-side counterpart of the LED matrix drive: it strobes the rows of an 8x8 key/switch matrix with one-cold row lines and samples the active-low column returns. Each key is debounced, and a stable key-state map is maintained. Every debounced press or release is emitted as an event through a valid/ready FIFO interface. The pattern-editing logic consumes these events, so the editor no longer polls raw buttons.

Parameters:
ROWS, 8, number of row strobe lines (index width clog2(ROWS)).
COLS, 8, number of column return lines (index width clog2(COLS)).
SCAN_DIV, 8192, clk cycles each row is driven; must be >= COLS+2.
DEBOUNCE, 4, consecutive differing samples needed to flip a key's stable state; must be >= 1.
FIFO_DEPTH, 4, event FIFO entries; power of two.

Ports:
clk  in  1  system clock (27 MHz on board)
rst  in  1  synchronous reset, active-low
row_n  out  ROWS  row strobes, one-cold; the driven row is 0
col_n  in  COLS  column returns, active-low (0 = key closed on the driven row)
evt_valid  out  1  event available at FIFO head
evt_ready  in  1  consumer accepts the head event
evt_press  out  1  1 = press, 0 = release
evt_row  out  clog2(ROWS)  row index of the event key
evt_col  out  clog2(COLS)  column index of the event key
key_state  out  ROWS*COLS  debounced state, bit r*COLS+c; 1 = held
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow (one-cycle pulse)

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-low (rst==0 sampled at posedge clk).
- Reset values:
  - row_n all ones.
  - evt_valid 0; evt_press, evt_row and evt_col 0.
  - key_state 0; overflow 0.
  - Debounce counters 0, divider 0, row index 0, FIFO empty.
  - Reset mid-scan or mid-processing aborts all activity; nothing in flight survives.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - row_n = ~(1<<row_idx) whenever rst==1. The first cycle after reset release drives row 0.
  - On the cycle with div==SCAN_DIV-1: latch col_n into samp and row_idx into samp_row, then advance row_idx (ROWS-1 wraps to 0).
  - The late sample gives each row a full slot to settle.
- Column processing:
  - During div 0..COLS-1 of the following slot, one column c=div is handled per cycle for key k = samp_row*COLS+c.
  - Let s=~samp[c]. If s==key_state[k], set cnt[k]=0.
  - Otherwise cnt[k]+1. If that reaches DEBOUNCE, key_state[k] flips, cnt[k]=0, and an event {press=s, row=samp_row, col=c} is pushed.
  - Debounce time = DEBOUNCE*ROWS*SCAN_DIV cycles, about 9.7 ms at the defaults.
  - A glitch shorter than DEBOUNCE consecutive scans produces no event and resets the counter.
- FIFO and handshake:
  - evt_valid is asserted while the FIFO is non-empty. The head fields are registered and stable while evt_valid&&!evt_ready.
  - A pop happens on evt_valid&&evt_ready.
  - Latency: push into an empty FIFO at cycle t gives evt_valid=1 at cycle t+1.
  - Push and pop in the same cycle are both accepted, including when the FIFO is full (the pop frees a slot).
  - Push while full with no pop: the event is dropped, overflow is set, and key_state still flips. key_state is always authoritative.
- Overflow: ovf_clr clears overflow. If ovf_clr and a drop occur in the same cycle, the set wins.
- Pointers: wrap modulo FIFO_DEPTH, with an extra wrap bit to tell full from empty.

Decomposition:
- Shared package (kmx_pkg):
  - default ROWS/COLS constants;
  - key_evt_t struct {press, row, col};
  - KEY_INDEX(row,col) helper.
- One sub-module, key_evt_fifo: a parameterised synchronous FIFO of key_evt_t with valid/ready output, full flag and same-cycle push/pop.
- The scanner, divider and debounce logic stay in key_matrix_scanner.

Test Plan:
Bench parameters: SCAN_DIV=16, DEBOUNCE=2, FIFO_DEPTH=4 (one full scan = 128 cycles).
1. Reset: hold rst=0 for 5 cycles -> row_n=8'hFF, evt_valid=0, key_state=0. The first cycle after release gives row_n=8'hFE; 16 cycles later row_n=8'hFD; after 128 cycles it is back to 8'hFE.
2. Press: drive col_n[5]=0 whenever row_n[2]==0, with evt_ready=1. After the second row-2 sample -> one event press=1, row=2, col=5; key_state[21]=1; no further events while held.
3. Bounce: key (2,5) closed for one scan only -> no event, key_state[21] stays 0.
4. Release: open (2,5) after test 2 -> after 2 scans, one event press=0, row=2, col=5; key_state[21]=0.
5. Overflow: evt_ready=0, close columns 0..4 of row 7 simultaneously for 2 scans -> 4 events queued in order col 0..3; col 4 dropped; overflow=1; key_state[60:56]=5'b11111. Then evt_ready=1 -> exactly 4 pops; an ovf_clr pulse clears overflow.
6. Mid-operation reset: assert rst=0 during column processing with 2 events queued -> evt_valid=0, key_state=0, FIFO empty next cycle. After release with keys still held, fresh press events appear after 2 scans.
